sum_accum: RTL and testbench

Parametrised registered arithmetic unit, successor to the fixed 4-bit nibble adder in the Tiny Tapeout user design. Adds, subtracts or accumulates two W-bit operands under a valid strobe, with a registered result, status flags, an accumulation sample counter and a block-done pulse every N accumulations. It sits between the input switch/bidir decode and the output driver of a `tt_um_*` top.

---
 rtl/sum_accum.sv | 148 ++++++++++++++
 tb/tb_sum_accum.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// Registered add / subtract / accumulate unit with status flags, a saturating
// sample counter and a block-done pulse every N accumulations.
module sum_accum #(
  parameter int unsigned W    = 4,
  parameter int unsigned ACCW = 8,
  parameter int unsigned CNTW = 8,
  parameter int unsigned N    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            in_valid,
  input  logic [W-1:0]    op_a,
  input  logic [W-1:0]    op_b,
  input  logic [1:0]      mode,
  input  logic            sat_en,
  output logic            out_valid,
  output logic [ACCW-1:0] result,
  output logic [2:0]      flags,
  output logic [CNTW-1:0] count,
  output logic            block_done
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] BLK_LAST = CNTW'(N - 1);

  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            neg_q, neg_d;
  logic            carry_q, carry_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] blk_q, blk_d;
  logic            out_valid_q, out_valid_d;
  logic            block_done_q, block_done_d;

  logic            accept;
  mode_e           op;
  logic [W:0]      add_w;
  logic [W:0]      sub_w;
  logic [ACCW:0]   acc_sum;

  assign accept  = ena & in_valid;
  assign op      = mode_e'(mode);
  assign add_w   = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w   = {1'b0, op_a} - {1'b0, op_b};
  assign acc_sum = {1'b0, acc_q} + (ACCW+1)'(op_a) + (ACCW+1)'(op_b);

  // blk_q tracks count modulo N so the block pulse needs no divider.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    acc_d        = acc_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    neg_d        = neg_q;
    carry_d      = carry_q;
    count_d      = count_q;
    blk_d        = blk_q;
    out_valid_d  = 1'b0;
    block_done_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      unique case (op)
        MODE_ADD: begin
          result_d = ACCW'(add_w);
          carry_d  = add_w[W];
          neg_d    = 1'b0;
        end
        MODE_SUB: begin
          result_d = ACCW'($signed(sub_w));
          neg_d    = (op_a < op_b);
          carry_d  = 1'b0;
        end
        MODE_ACC: begin
          if (acc_sum[ACCW]) begin
            ovf_d = 1'b1;
            acc_d = sat_en ? '1 : acc_sum[ACCW-1:0];
          end else begin
            acc_d = acc_sum[ACCW-1:0];
          end
          result_d = acc_d;
          carry_d  = acc_sum[ACCW];
          neg_d    = 1'b0;
          // A saturated counter stops both counting and block pulses.
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
            if (blk_q == BLK_LAST) begin
              blk_d        = '0;
              block_done_d = 1'b1;
            end else begin
              blk_d = blk_q + CNT_ONE;
            end
          end
        end
        MODE_CLR: begin
          acc_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          neg_d    = 1'b0;
          carry_d  = 1'b0;
          count_d  = '0;
          blk_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      carry_q      <= 1'b0;
      count_q      <= '0;
      blk_q        <= '0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      acc_q        <= acc_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      neg_q        <= neg_d;
      carry_q      <= carry_d;
      count_q      <= count_d;
      blk_q        <= blk_d;
      out_valid_q  <= out_valid_d;
      block_done_q <= block_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flags      = {ovf_q, neg_q, carry_q};
  assign count      = count_q;
  assign block_done = block_done_q;

endmodule

// File: tb/tb_sum_accum.sv
// Randomised self-checking bench for sum_accum against an integer reference model;
// a second instance with a 3-bit counter covers counter saturation.
module tb_sum_accum;

  localparam int W       = 4;
  localparam int ACCW    = 8;
  localparam int CNTW    = 8;
  localparam int N       = 4;
  localparam int OP_MAX  = (1 << W) - 1;
  localparam int ACC_MAX = (1 << ACCW) - 1;
  localparam int CNT_MAX = (1 << CNTW) - 1;
  localparam int OBS_W   = 1 + ACCW + 3 + CNTW + 1;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic            in_valid;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [1:0]      mode;
  logic            sat_en;

  logic            out_valid;
  logic [ACCW-1:0] result;
  logic [2:0]      flags;
  logic [CNTW-1:0] count;
  logic            block_done;

  logic            out_valid2;
  logic [ACCW-1:0] result2;
  logic [2:0]      flags2;
  logic [2:0]      count2;
  logic            block_done2;

  sum_accum #(.W(W), .ACCW(ACCW), .CNTW(CNTW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .op_a(op_a), .op_b(op_b), .mode(mode), .sat_en(sat_en),
    .out_valid(out_valid), .result(result), .flags(flags),
    .count(count), .block_done(block_done)
  );

  sum_accum #(.W(W), .ACCW(ACCW), .CNTW(3), .N(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .op_a(op_a), .op_b(op_b), .mode(mode), .sat_en(sat_en),
    .out_valid(out_valid2), .result(result2), .flags(flags2),
    .count(count2), .block_done(block_done2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, plain integers.
  int m_acc, m_res, m_cnt;
  bit m_ovf, m_neg, m_carry, m_ov, m_bd;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] exp_vec;
  assign obs = {out_valid, result, flags, count, block_done};

  task automatic model_reset();
    m_acc = 0; m_res = 0; m_cnt = 0;
    m_ovf = 0; m_neg = 0; m_carry = 0; m_ov = 0; m_bd = 0;
    exp_vec = '0;
  endtask

  // Drive one cycle of stimulus (called at a falling edge), let the rising edge
  // take it, return at the next falling edge with the model advanced.
  task automatic apply(input bit v, input logic [1:0] md, input int a, input int b,
                       input bit sat, input bit en);
    int s;
    ena = en; in_valid = v; mode = md; sat_en = sat;
    op_a = W'(a); op_b = W'(b);
    @(posedge clk);
    @(negedge clk);
    m_ov = 0; m_bd = 0;
    if (en && v) begin
      m_ov = 1;
      case (md)
        M_ADD: begin
          s = a + b;
          m_res = s; m_carry = (s > OP_MAX); m_neg = 0;
        end
        M_SUB: begin
          s = a - b;
          m_res = (s + ACC_MAX + 1) % (ACC_MAX + 1);
          m_neg = (a < b); m_carry = 0;
        end
        M_ACC: begin
          s = m_acc + a + b;
          m_carry = (s > ACC_MAX);
          if (s > ACC_MAX) begin
            m_ovf = 1;
            m_acc = sat ? ACC_MAX : s - (ACC_MAX + 1);
          end else begin
            m_acc = s;
          end
          m_res = m_acc; m_neg = 0;
          if (m_cnt < CNT_MAX) begin
            m_cnt = m_cnt + 1;
            m_bd  = (m_cnt % N == 0);
          end
        end
        default: begin
          m_acc = 0; m_res = 0; m_cnt = 0;
          m_ovf = 0; m_neg = 0; m_carry = 0;
        end
      endcase
    end
    exp_vec = {m_ov, ACCW'(m_res), m_ovf, m_neg, m_carry, CNTW'(m_cnt), m_bd};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; mode = M_ADD;
    op_a = '0; op_b = '0; sat_en = 1'b0;
    model_reset();
    #3;
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL reset_main: got %h expected %h", obs, exp_vec);
    end
    total++;
    if ({out_valid2, result2, flags2, count2, block_done2} !== '0) begin
      bad++; $display("FAIL reset_small: got cnt=%0d res=%h expected zeros", count2, result2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    apply(1, M_ADD, 9, 8, 0, 1);
    total++;
    if (obs !== exp_vec || result !== 8'h11 || flags !== 3'b001) begin
      bad++; $display("FAIL add_9_8: got %h expected %h", obs, exp_vec);
    end
    apply(0, M_ADD, 9, 8, 0, 1);
    total++;
    if (obs !== exp_vec || out_valid !== 1'b0) begin
      bad++; $display("FAIL add_pulse_width: got %h expected %h", obs, exp_vec);
    end
    apply(1, M_ADD, 15, 15, 0, 1);
    total++;
    if (obs !== exp_vec || result !== 8'h1E || flags[0] !== 1'b1) begin
      bad++; $display("FAIL add_15_15: got %h expected %h", obs, exp_vec);
    end
    apply(1, M_SUB, 3, 5, 0, 1);
    total++;
    if (obs !== exp_vec || result !== 8'hFE || flags[1] !== 1'b1) begin
      bad++; $display("FAIL sub_3_5: got %h expected %h", obs, exp_vec);
    end
    apply(1, M_SUB, 5, 3, 0, 1);
    total++;
    if (obs !== exp_vec || result !== 8'h02 || flags[1] !== 1'b0) begin
      bad++; $display("FAIL sub_5_3: got %h expected %h", obs, exp_vec);
    end
    for (int i = 0; i < 24; i++) begin
      apply(1, (i % 2 == 0) ? M_ADD : M_SUB, $urandom_range(0, OP_MAX),
            $urandom_range(0, OP_MAX), 0, 1);
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL add_sub_rand[%0d]: got %h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  task automatic test_acc(input bit sat);
    int bd_seen;
    bd_seen = 0;
    apply(1, M_CLR, 0, 0, sat, 1);
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL acc_clr_start: got %h expected %h", obs, exp_vec);
    end
    for (int i = 1; i <= 9; i++) begin
      apply(1, M_ACC, 15, 15, sat, 1);
      total++;
      if (obs !== exp_vec || block_done !== ((i == 4) || (i == 8))) begin
        bad++; $display("FAIL acc_step[%0d] sat=%0d: got %h expected %h", i, sat, obs, exp_vec);
      end
      if (block_done === 1'b1) bd_seen++;
    end
    total++;
    if (result !== (sat ? 8'hFF : 8'h0E) || flags !== 3'b101 || count !== 8'd9 || bd_seen != 2) begin
      bad++; $display("FAIL acc_ninth sat=%0d: got res=%h flags=%b cnt=%0d bd=%0d expected res=%h flags=101 cnt=9 bd=2",
                      sat, result, flags, count, bd_seen, sat ? 8'hFF : 8'h0E);
    end
    apply(1, M_ADD, 1, 2, sat, 1);
    total++;
    if (obs !== exp_vec || flags[2] !== 1'b1) begin
      bad++; $display("FAIL acc_sticky_after_add: got %h expected %h", obs, exp_vec);
    end
    apply(1, M_CLR, 7, 7, sat, 1);
    total++;
    if (obs !== exp_vec || flags !== 3'b000 || result !== '0 || count !== '0) begin
      bad++; $display("FAIL acc_clr_end: got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_ena();
    logic [ACCW-1:0] held_res;
    logic [CNTW-1:0] held_cnt;
    apply(1, M_ACC, 6, 7, 0, 1);
    held_res = result;
    held_cnt = count;
    for (int i = 0; i < 3; i++) begin
      apply(1, M_ACC, 5, 5, 0, 0);
      total++;
      if (obs !== exp_vec || out_valid !== 1'b0 || result !== held_res || count !== held_cnt) begin
        bad++; $display("FAIL ena_hold[%0d]: got %h expected %h", i, obs, exp_vec);
      end
    end
    apply(1, M_ACC, 5, 5, 0, 1);
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL ena_resume: got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] md;
    for (int i = 0; i < 300; i++) begin
      md = ($urandom_range(0, 19) == 0) ? M_CLR : 2'($urandom_range(0, 2));
      apply($urandom_range(0, 7) != 0, md, $urandom_range(0, OP_MAX),
            $urandom_range(0, OP_MAX), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) != 0);
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL b2b[%0d] mode=%0d: got %h expected %h", i, md, obs, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) apply(1, M_ACC, 11, 12, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs !== exp_vec || {out_valid2, result2, flags2, count2, block_done2} !== '0) begin
      bad++; $display("FAIL async_reset: got %h expected %h", obs, exp_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, M_ACC, 0, 0, 0, 1);
    total++;
    if (obs !== exp_vec) begin
      bad++; $display("FAIL after_reset_idle: got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_small_cnt();
    int exp_c;
    apply(1, M_CLR, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      apply(1, M_ACC, 0, 0, 0, 1);
      exp_c = (i < 7) ? i : 7;
      total++;
      if (count2 !== 3'(exp_c) || block_done2 !== (i == 4) || out_valid2 !== 1'b1) begin
        bad++; $display("FAIL small_cnt[%0d]: got cnt=%0d bd=%b ov=%b expected cnt=%0d bd=%b ov=1",
                        i, count2, block_done2, out_valid2, exp_c, (i == 4));
      end
      total++;
      if (obs !== exp_vec) begin
        bad++; $display("FAIL small_cnt_main[%0d]: got %h expected %h", i, obs, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_acc(1'b1);
    test_acc(1'b0);
    test_ena();
    test_back_to_back();
    test_async_reset();
    test_small_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
